mdu_hilo: RTL and testbench
===========================

// Module: mdu_hilo
// PURPOSE
//   Multiply/divide unit owning the HI/LO registers of the pipelined MIPS core.
//   Sits in EX beside the ALU. It is the producer that feeds the HI/LO inputs of
//   the EX result select (MFHI/MFLO), and it drives busy to the hazard unit.
//   Operations are multi-cycle; busy is the only timing contract with the pipeline.
// PARAMETERS
//   MULT_CYCLES  5   busy duration of MULT/MULTU/MADD/MADDU, in cycles (>=1)
//   DIV_CYCLES   10  busy duration of DIV/DIVU, in cycles (>=1)
// PORTS
//   clk    in   1   clock; all state changes on rising edge
//   reset  in   1   asynchronous, active-high reset
//   start  in   1   op request, sampled on rising edge
//   op     in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU
//   a      in   32  operand rs (MTHI/MTLO source)
//   b      in   32  operand rt
//   busy   out  1   registered; high while a multi-cycle op is in flight
//   hi     out  32  HI register (registered)
//   lo     out  32  LO register (registered)
// BEHAVIOUR
//   - Reset: busy=0, hi=0, lo=0, internal counter=0, latched operands cleared.
//     Reset mid-operation aborts the op; no partial result is ever written.
//   - Accept: start=1 at an edge with busy=0. Any start while busy=1 is ignored,
//     including MTHI/MTLO. This includes the last busy cycle.
//   - MTHI/MTLO: hi<=a / lo<=a at the accepting edge; busy stays 0.
//   - Mult/div: at the accepting edge, a, b and op are latched and the counter
//     is loaded with LAT (MULT_CYCLES or DIV_CYCLES). busy=(counter!=0).
//     The counter decrements each edge. On the 1->0 edge, hi/lo are written
//     and busy falls. busy is therefore high for exactly LAT cycles, and the new
//     hi/lo are visible in the first cycle with busy=0.
//   - hi/lo keep their old values throughout busy. Later changes to a/b do not
//     affect the op in flight.
//   - MULT: {hi,lo}=$signed(a)*$signed(b) (64-bit). MULTU: unsigned 64-bit.
//   - DIV: lo=quotient truncated toward zero; hi=remainder, with the sign of the
//     dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
//     DIVU: unsigned quotient/remainder.
//   - Divide by zero (b==0): busy runs the full DIV_CYCLES; hi/lo are left
//     unchanged.
//   - Products and quotients are computed on the latched operands. The
//     counter only models latency; a combinational result is allowed.
// CONFIGURATION
//   MDU_MADD_EN defined:
//     op 6 MADD:  {hi,lo} <= {hi,lo} + $signed(a)*$signed(b)
//     op 7 MADDU: unsigned form of MADD
//     Both take MULT_CYCLES. The addend is {hi,lo} at completion, mod 2^64.
//   MDU_MADD_EN undefined:
//     op 6/7 are no-ops: start is ignored, busy stays 0, hi/lo unchanged.
// TESTING
//   1. reset pulse mid-cycle (async), no clk edge -> busy=0, hi=0, lo=0 immediately
//   2. MULT a=0xFFFFFFFE(-2), b=3 -> busy high exactly 5 cycles, then
//      hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x2, lo=0xFFFFFFFA
//   3. DIV a=0xFFFFFFF9(-7), b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF;
//      DIV b=0 -> busy 10 cycles, hi/lo unchanged
//   4. MTHI a=0x12345678 -> next edge hi=0x12345678, busy=0; MTLO while
//      busy=1 -> ignored, lo is the op result
//   5. start MULT, then reset at cycle 3 of busy -> busy=0, hi=lo=0, no later write
//   6. MDU_MADD_EN: hi=0, lo=0xFFFFFFFF; MADDU a=1, b=1 -> hi=1, lo=0
//      without macro: op 6 -> busy stays 0, hi/lo unchanged

Source files
------------

// File: rtl/mdu_hilo.sv
// ----------------------------------------------------------------------------
// mdu_hilo - multiply/divide unit owning the HI/LO registers of the MIPS core.
//
// Sits in EX beside the ALU. It supplies HI/LO to the MFHI/MFLO result select
// and raises busy towards the hazard unit while a multi-cycle op is in flight.
// The latency counter only models timing. The product and quotient are formed
// combinationally from the operands latched at the accepting edge. They are
// written to HI/LO on the edge where the counter steps from 1 to 0.
//
// Parameters
//   MULT_CYCLES  busy length of MULT/MULTU (and MADD/MADDU), >= 1
//   DIV_CYCLES   busy length of DIV/DIVU, >= 1
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous, active-high reset
//   start  in   1   op request, honoured only while busy is low
//   op     in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO,
//                   6 MADD, 7 MADDU
//   a      in   32  operand rs (also the MTHI/MTLO source)
//   b      in   32  operand rt
//   busy   out  1   high while a multi-cycle op is in flight
//   hi     out  32  HI register
//   lo     out  32  LO register
//
// Configuration
//   MDU_MADD_EN  when defined, op 6/7 accumulate a product into {HI,LO}.
//                When undefined, op 6/7 are ignored.
// ----------------------------------------------------------------------------
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MADDU = 3'd7
  } op_e;

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_LAT + 1);

  // Architectural and in-flight state
  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  op_e           r_op;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  // Request decode
  logic          w_accept;
  logic          w_is_long;
  logic [CW-1:0] w_lat;

  // Datapath on latched operands
  logic [63:0]   w_prod_s;
  logic [63:0]   w_prod_u;
  logic [31:0]   w_a_mag;
  logic [31:0]   w_b_mag;
  logic [31:0]   w_b_mag_safe;
  logic [31:0]   w_b_safe;
  logic [31:0]   w_mag_q;
  logic [31:0]   w_mag_r;
  logic [31:0]   w_sdiv_q;
  logic [31:0]   w_sdiv_r;
  logic [31:0]   w_udiv_q;
  logic [31:0]   w_udiv_r;

  // Completion write
  logic          w_res_we;
  logic [31:0]   w_res_hi;
  logic [31:0]   w_res_lo;

  assign w_accept = start & ~r_busy;

  // Decide whether the requested op is multi-cycle and how long it runs.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    w_is_long = 1'b0;
    w_lat     = '0;
    case (op_e'(op))
      OP_MULT, OP_MULTU: begin
        w_is_long = 1'b1;
        w_lat     = CW'(MULT_CYCLES);
      end
      OP_DIV, OP_DIVU: begin
        w_is_long = 1'b1;
        w_lat     = CW'(DIV_CYCLES);
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: begin
        w_is_long = 1'b1;
        w_lat     = CW'(MULT_CYCLES);
      end
`endif
      default: begin
        w_is_long = 1'b0;
        w_lat     = '0;
      end
    endcase
  end

  // 64-bit products. Operands are extended explicitly so the low 64 bits of
  // the wide multiply are the exact signed or unsigned product.
  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Signed division runs on magnitudes. This keeps 0x80000000 / -1 well
  // defined (quotient 0x80000000, remainder 0) with no signed overflow. The
  // divisor is forced non-zero so a zero divide never reaches the divider.
  // The zero-divide result is discarded anyway.
  assign w_a_mag      = r_a[31] ? (~r_a + 32'd1) : r_a;
  assign w_b_mag      = r_b[31] ? (~r_b + 32'd1) : r_b;
  assign w_b_mag_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
  assign w_b_safe     = (r_b == 32'd0) ? 32'd1 : r_b;

  assign w_mag_q  = w_a_mag / w_b_mag_safe;
  assign w_mag_r  = w_a_mag % w_b_mag_safe;
  // Quotient truncates toward zero; remainder takes the dividend's sign.
  assign w_sdiv_q = (r_a[31] ^ r_b[31]) ? (~w_mag_q + 32'd1) : w_mag_q;
  assign w_sdiv_r = r_a[31] ? (~w_mag_r + 32'd1) : w_mag_r;
  assign w_udiv_q = r_a / w_b_safe;
  assign w_udiv_r = r_a % w_b_safe;

  // Result selected by the latched op. Consumed only on the final busy edge.
  always_comb begin
    w_res_we = 1'b0;
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (r_op)
      OP_MULT: begin
        w_res_we             = 1'b1;
        {w_res_hi, w_res_lo} = w_prod_s;
      end
      OP_MULTU: begin
        w_res_we             = 1'b1;
        {w_res_hi, w_res_lo} = w_prod_u;
      end
      OP_DIV: begin
        w_res_we = (r_b != 32'd0);
        w_res_hi = w_sdiv_r;
        w_res_lo = w_sdiv_q;
      end
      OP_DIVU: begin
        w_res_we = (r_b != 32'd0);
        w_res_hi = w_udiv_r;
        w_res_lo = w_udiv_q;
      end
`ifdef MDU_MADD_EN
      // The addend is {HI,LO} as it stands at completion. HI/LO cannot change
      // while busy, so this equals the value at issue.
      OP_MADD: begin
        w_res_we             = 1'b1;
        {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_prod_s;
      end
      OP_MADDU: begin
        w_res_we             = 1'b1;
        {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_prod_u;
      end
`endif
      default: begin
        w_res_we = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // pre-edge values. That mirrors the hardware and avoids evaluation-order races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= OP_MULT;
      r_hi   <= '0;
      r_lo   <= '0;
    end else if (w_accept) begin
      if (op_e'(op) == OP_MTHI) r_hi <= a;
      if (op_e'(op) == OP_MTLO) r_lo <= a;
      if (w_is_long) begin
        r_a    <= a;
        r_b    <= b;
        r_op   <= op_e'(op);
        r_cnt  <= w_lat;
        r_busy <= 1'b1;
      end
    end else if (r_busy) begin
      // busy mirrors (r_cnt != 0). The 1->0 step retires the op.
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        if (w_res_we) begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
      end
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// ----------------------------------------------------------------------------
// tb_mdu_hilo - self-checking bench for mdu_hilo.
//
// Multi-cycle ops push {name, busy length, hi, lo} into a scoreboard queue
// when issued. A monitor counts busy cycles on each falling clock edge. When
// busy drops, it pops the queue and compares both the busy length and HI/LO.
// Single-edge effects (reset, MTHI/MTLO, ignored ops) are checked directly.
// Build with MDU_MADD_EN defined to exercise MADD/MADDU.
// ----------------------------------------------------------------------------
module tb_mdu_hilo;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mdu_hilo #(
    .MULT_CYCLES(MULT_LAT),
    .DIV_CYCLES (DIV_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: counts busy cycles and compares when busy drops.
  int   mon_busy_cnt = 0;
  logic mon_prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      mon_busy_cnt  = 0;
      mon_prev_busy = 1'b0;
    end else begin
      if (busy === 1'b1) mon_busy_cnt++;
      if (mon_prev_busy && busy === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_completion: got hi=0x%0h lo=0x%0h, expected no completion", hi, lo);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_busy_cycles"}, 64'(mon_busy_cnt), 64'(e.cyc));
          check({e.name, "_hilo"}, {hi, lo}, {e.hi, e.lo});
        end
        mon_busy_cnt = 0;
      end
      mon_prev_busy = (busy === 1'b1);
    end
  end

  // Present one request for exactly one rising edge, then scramble operands
  // so an in-flight op that failed to latch them would be caught.
  task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check({name, "_idle_timeout"}, 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic run_long(input string name, input logic [2:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input int cyc,
                          input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    e.name = name;
    e.cyc  = cyc;
    e.hi   = ehi;
    e.lo   = elo;
    exp_q.push_back(e);
    issue(o, va, vb);
    wait_idle(name, cyc + 5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;

    // 1. Asynchronous reset mid-cycle, checked before any clock edge.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi",   64'(hi),   64'd0);
    check("reset_lo",   64'(lo),   64'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // 2. Multiply, signed and unsigned.
    run_long("mult_m2x3",  OP_MULT,  32'hFFFF_FFFE, 32'd3, MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    // hi/lo must hold the old result while the next op is in flight.
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    begin
      exp_t e;
      e.name = "multu_m2x3";
      e.cyc  = MULT_LAT;
      e.hi   = 32'h0000_0002;
      e.lo   = 32'hFFFF_FFFA;
      exp_q.push_back(e);
    end
    check("hilo_held_during_busy", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    wait_idle("multu_m2x3", MULT_LAT + 5);

    // 3. Divide, including sign rules, overflow case and divide by zero.
    run_long("div_m7d2",    OP_DIV,  32'hFFFF_FFF9, 32'd2,          DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_long("div_by_zero", OP_DIV,  32'd1234,      32'd0,          DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_long("div_7dm2",    OP_DIV,  32'd7,         32'hFFFF_FFFE,  DIV_LAT, 32'h0000_0001, 32'hFFFF_FFFD);
    run_long("div_minint",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  DIV_LAT, 32'h0000_0000, 32'h8000_0000);
    run_long("divu_100d7",  OP_DIVU, 32'd100,       32'd7,          DIV_LAT, 32'h0000_0002, 32'h0000_000E);
    run_long("divu_big",    OP_DIVU, 32'hFFFF_FFF9, 32'd2,          DIV_LAT, 32'h0000_0001, 32'h7FFF_FFFC);
    run_long("divu_by_zero",OP_DIVU, 32'd55,        32'd0,          DIV_LAT, 32'h0000_0001, 32'h7FFF_FFFC);

    // 4. MTHI/MTLO take effect at the accepting edge without raising busy.
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    check("mthi_hi",   64'(hi),   64'h1234_5678);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_lo",   64'(lo),   64'h7FFF_FFFC);
    issue(OP_MTLO, 32'hCAFE_F00D, 32'd0);
    check("mtlo_lo",   64'(lo),   64'hCAFE_F00D);

    // MTLO held on start through every busy edge, including the last, is ignored.
    begin
      exp_t e;
      e.name = "mult_6x7_mtlo_ignored";
      e.cyc  = MULT_LAT;
      e.hi   = 32'd0;
      e.lo   = 32'd42;
      exp_q.push_back(e);
    end
    issue(OP_MULT, 32'd6, 32'd7);
    start = 1'b1;
    op    = OP_MTLO;
    a     = 32'hDEAD_BEEF;
    repeat (MULT_LAT) @(posedge clk);
    #1 start = 1'b0;
    wait_idle("mult_6x7_mtlo_ignored", MULT_LAT + 5);
    check("mtlo_ignored_lo_after", 64'(lo), 64'd42);

    // 5. Reset during the third busy cycle aborts with no later write.
    issue(OP_MTHI, 32'h0000_0011, 32'd0);
    issue(OP_MULT, 32'd5, 32'd5);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (MULT_LAT + 3) @(negedge clk);
    check("abort_no_late_write", {31'd0, busy, hi, lo}, 64'd0);

    // 6. MADD/MADDU when built in, otherwise ignored.
    issue(OP_MTHI, 32'h0000_0000, 32'd0);
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
`ifdef MDU_MADD_EN
    @(negedge clk);
    run_long("maddu_1x1", OP_MADDU, 32'd1, 32'd1,         MULT_LAT, 32'h0000_0001, 32'h0000_0000);
    run_long("madd_m1x1", OP_MADD,  32'hFFFF_FFFF, 32'd1, MULT_LAT, 32'h0000_0000, 32'hFFFF_FFFF);
    run_long("madd_m2x3", OP_MADD,  32'hFFFF_FFFE, 32'd3, MULT_LAT, 32'h0000_0000, 32'hFFFF_FFF9);
`else
    issue(OP_MADD, 32'd3, 32'd4);
    check("madd_off_busy", 64'(busy), 64'd0);
    issue(OP_MADDU, 32'd1, 32'd1);
    check("maddu_off_busy", 64'(busy), 64'd0);
    repeat (MULT_LAT + 2) @(negedge clk);
    check("madd_off_hilo", {31'd0, busy, hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
